// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between pipeline writeback and long-latency returns
// One-entry return buffer, starvation-driven pipeline stall and a pending-destination scoreboard.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_wa,
    input  logic [31:0] lu_wd,
    input  logic        iss_valid,
    input  logic [4:0]  iss_wa,
    output logic        rf_we3,
    output logic [4:0]  rf_wa3,
    output logic [31:0] rf_wd3,
    output logic [31:0] pend,
    output logic        stall_req,
    output logic        collision_err
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             buf_valid;
    logic [4:0]       buf_wa;
    logic [31:0]      buf_wd;
    logic [CNT_W-1:0] starve_cnt;

    logic             pipe_req;
    logic             buf_sel;
    logic             buf_drain;
    logic [CNT_W-1:0] cnt_next;
    logic [31:0]      pend_next;

    assign lu_ready = reset && !buf_valid;

    always_comb begin
        pipe_req  = pipe_we && (pipe_wa != 5'd0) && !stall_req;
        buf_sel   = buf_valid && (stall_req || !pipe_req);
        // A buffered r0 return is dropped right away without taking the port.
        buf_drain = buf_sel || (buf_valid && (buf_wa == 5'd0));

        rf_we3 = 1'b0;
        rf_wa3 = 5'd0;
        rf_wd3 = 32'd0;
        if (buf_sel) begin
            rf_we3 = reset && (buf_wa != 5'd0);
            rf_wa3 = buf_wa;
            rf_wd3 = buf_wd;
        end else if (pipe_req) begin
            rf_we3 = reset;
            rf_wa3 = pipe_wa;
            rf_wd3 = pipe_wd;
        end
    end

    always_comb begin
        if (!buf_valid || buf_drain)
            cnt_next = '0;
        else if (starve_cnt >= LIMIT)
            cnt_next = LIMIT;
        else
            cnt_next = starve_cnt + 1'b1;
    end

    always_comb begin
        pend_next = pend;
        if (buf_sel && (buf_wa != 5'd0))
            pend_next[buf_wa] = 1'b0;
        // Issue is applied after the clear so a same-index collision keeps the bit set.
        if (iss_valid && (iss_wa != 5'd0))
            pend_next[iss_wa] = 1'b1;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid     <= 1'b0;
            buf_wa        <= 5'd0;
            buf_wd        <= 32'd0;
            starve_cnt    <= '0;
            stall_req     <= 1'b0;
            collision_err <= 1'b0;
            pend          <= 32'd0;
        end else begin
            if (buf_drain) begin
                buf_valid <= 1'b0;
            end else if (lu_valid && lu_ready) begin
                buf_valid <= 1'b1;
                buf_wa    <= lu_wa;
                buf_wd    <= lu_wd;
            end
            starve_cnt    <= cnt_next;
            stall_req     <= (cnt_next == LIMIT) && buf_valid && !buf_drain;
            collision_err <= collision_err || (stall_req && pipe_we);
            pend          <= pend_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed checks of regfile_wb_arbiter against a queue-based model
// The model tracks the return buffer as a queue and applies the arbitration rules cycle by cycle.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_wa = 5'd0;
    logic [31:0] pipe_wd = 32'd0;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_wa = 5'd0;
    logic [31:0] lu_wd = 32'd0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_wa = 5'd0;
    logic        rf_we3;
    logic [4:0]  rf_wa3;
    logic [31:0] rf_wd3;
    logic [31:0] pend;
    logic        stall_req;
    logic        collision_err;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wa(lu_wa), .lu_wd(lu_wd),
        .iss_valid(iss_valid), .iss_wa(iss_wa),
        .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3),
        .pend(pend), .stall_req(stall_req), .collision_err(collision_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [36:0] m_buf[$];
    int          m_loss;
    bit          m_stall;
    bit          m_coll;
    logic [31:0] m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_loss  = 0;
        m_stall = 0;
        m_coll  = 0;
        m_pend  = 32'd0;
    endtask

    task automatic step(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                        input logic lv, input logic [4:0] lwa, input logic [31:0] lwd,
                        input logic iv, input logic [4:0] iwa);
        bit          has, pipe_ok, buf_go, leave, e_we;
        logic [4:0]  bwa, e_wa;
        logic [31:0] bwd, e_wd;
        @(negedge clk);
        pipe_we = pwe; pipe_wa = pwa; pipe_wd = pwd;
        lu_valid = lv; lu_wa = lwa; lu_wd = lwd;
        iss_valid = iv; iss_wa = iwa;
        #1;
        has = (m_buf.size() != 0);
        bwa = has ? m_buf[0][36:32] : 5'd0;
        bwd = has ? m_buf[0][31:0] : 32'd0;
        pipe_ok = pwe && (pwa != 5'd0) && !m_stall;
        buf_go  = has && (m_stall || !pipe_ok);
        e_we = 0; e_wa = 5'd0; e_wd = 32'd0;
        if (buf_go) begin
            e_we = (bwa != 5'd0); e_wa = bwa; e_wd = bwd;
        end else if (pipe_ok) begin
            e_we = 1; e_wa = pwa; e_wd = pwd;
        end
        chk("lu_ready", {31'd0, lu_ready}, {31'd0, !has});
        chk("rf_we3", {31'd0, rf_we3}, {31'd0, e_we});
        if (e_we) begin
            chk("rf_wa3", {27'd0, rf_wa3}, {27'd0, e_wa});
            chk("rf_wd3", rf_wd3, e_wd);
        end
        chk("pend", pend, m_pend);
        chk("stall_req", {31'd0, stall_req}, {31'd0, m_stall});
        chk("collision_err", {31'd0, collision_err}, {31'd0, m_coll});

        m_coll = m_coll || (m_stall && pwe);
        if (buf_go && bwa != 5'd0) m_pend[bwa] = 1'b0;
        if (iv && iwa != 5'd0) m_pend[iwa] = 1'b1;
        leave = buf_go || (has && bwa == 5'd0);
        if (leave) begin
            void'(m_buf.pop_front());
            m_loss = 0;
            m_stall = 0;
        end else if (has) begin
            m_loss = (m_loss + 1 > LIMIT) ? LIMIT : m_loss + 1;
            m_stall = (m_loss == LIMIT);
        end else begin
            m_loss = 0;
            m_stall = 0;
        end
        if (!has && lv) m_buf.push_back({lwa, lwd});
    endtask

    task automatic idle();
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        lu_valid = 0; iss_valid = 0;
        pipe_we = 1; pipe_wa = 5'd5; pipe_wd = 32'h1234;
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
        chk("rst_rf_we3", {31'd0, rf_we3}, 32'd0);
        chk("rst_pend", pend, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_coll", {31'd0, collision_err}, 32'd0);
        @(negedge clk);
        pipe_we = 0; pipe_wa = 5'd0; pipe_wd = 32'd0;
        reset = 1'b1;
    endtask

    task automatic starve_run(input bit collide);
        step(1, 5'd9, 32'h99, 1, 5'd3, 32'h3333_0003, 0, 5'd0);
        for (int i = 0; i < LIMIT; i++) step(1, 5'd9, 32'h99 + i, 0, 5'd0, 32'd0, 0, 5'd0);
        step(collide, 5'd9, 32'h9999, 0, 5'd0, 32'd0, 0, 5'd0);
        chk("starve_stall_on", {31'd0, stall_req}, 32'd1);
        chk("starve_wa", {27'd0, rf_wa3}, 32'd3);
        chk("starve_wd", rf_wd3, 32'h3333_0003);
        idle();
        chk("starve_stall_off", {31'd0, stall_req}, 32'd0);
        chk("starve_coll", {31'd0, collision_err}, {31'd0, collide});
        idle();
        chk("starve_coll_sticky", {31'd0, collision_err}, {31'd0, collide});
    endtask

    initial begin
        model_reset();
        #12;
        chk("init_lu_ready", {31'd0, lu_ready}, 32'd0);
        chk("init_rf_we3", {31'd0, rf_we3}, 32'd0);
        chk("init_pend", pend, 32'd0);
        chk("init_stall", {31'd0, stall_req}, 32'd0);
        chk("init_coll", {31'd0, collision_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        step(0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0);
        chk("t1_handshake", {31'd0, lu_ready}, 32'd1);
        idle();
        chk("t1_we", {31'd0, rf_we3}, 32'd1);
        chk("t1_wa", {27'd0, rf_wa3}, 32'd5);
        chk("t1_wd", rf_wd3, 32'hDEADBEEF);
        idle();
        chk("t1_ready_again", {31'd0, lu_ready}, 32'd1);

        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7);
        idle();
        chk("t2_pend_set", {31'd0, pend[7]}, 32'd1);
        step(0, 5'd0, 32'd0, 1, 5'd7, 32'h7777, 0, 5'd0);
        idle();
        chk("t2_write_r7", {27'd0, rf_wa3}, 32'd7);
        chk("t2_pend_still", {31'd0, pend[7]}, 32'd1);
        idle();
        chk("t2_pend_clear", {31'd0, pend[7]}, 32'd0);

        starve_run(0);
        starve_run(1);
        do_reset();

        step(0, 5'd0, 32'd0, 1, 5'd4, 32'h4444, 0, 5'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd4);
        idle();
        chk("t5_set_wins", {31'd0, pend[4]}, 32'd1);
        step(0, 5'd0, 32'd0, 1, 5'd0, 32'h0BAD, 0, 5'd0);
        idle();
        chk("t5_r0_no_we", {31'd0, rf_we3}, 32'd0);
        idle();
        chk("t5_r0_drained", {31'd0, lu_ready}, 32'd1);

        do_reset();
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd4);
        step(0, 5'd0, 32'd0, 1, 5'd9, 32'h9, 1, 5'd7);
        step(1, 5'd1, 32'h1, 0, 5'd0, 32'd0, 0, 5'd0);
        chk("t6_pend_pre", pend, 32'h0000_0090);
        chk("t6_buf_full", {31'd0, lu_ready}, 32'd0);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            logic pwe, lv, iv;
            logic [4:0] pwa, lwa, iwa;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                pwe = m_stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 6);
                pwa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                lv  = $urandom_range(0, 1);
                lwa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                iv  = ($urandom_range(0, 9) < 3);
                iwa = 5'($urandom_range(0, 31));
                step(pwe, pwa, $urandom, lv, lwa, $urandom, iv, iwa);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
